scope_column_writer: RTL and testbench



---
 rtl/scope_pkg.sv | 28 ++
 rtl/scope_row_map.sv | 41 ++++
 rtl/scope_column_writer.sv | 192 +++++++++++++++++++
 tb/tb_scope_column_writer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
`default_nettype none
// scope_pkg: shared widths, colours and state encoding for the scope column writer.
// Revision: 1.0
package scope_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int COL_W    = 12;
  localparam int SAMPLE_W = 8;
  localparam int VOLT_W   = 4;
  localparam int TENTH_W  = 4;

  localparam logic [COL_W-1:0] COL_BG    = 12'h000;
  localparam logic [COL_W-1:0] COL_AXIS  = 12'h0F0;
  localparam logic [COL_W-1:0] COL_TRACE = 12'h010;

  localparam logic [Y_W-1:0] AXIS_TOP = 9'd234;
  localparam logic [Y_W-1:0] AXIS_BOT = 9'd246;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/scope_row_map.sv
`default_nettype none
// scope_row_map: maps a volts/tenths sample to the top row of its 13-row trace band.
// Revision: 1.0
module scope_row_map
  import scope_pkg::*;
#(
  parameter int BAND_H   = 13,
  parameter int BASE_ROW = 256
) (
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [Y_W-1:0]      top_row
);

  logic [VOLT_W-1:0]  volts;
  logic [VOLT_W-1:0]  v_sat;
  logic [TENTH_W-1:0] tenths;
  logic [1:0]         sub;
  logic [4:0]         band;
  logic [15:0]        offset;
  logic [15:0]        row_full;

  always_comb begin
    volts  = sample_data[7:4];
    tenths = sample_data[3:0];
    v_sat  = (volts > 4'd5) ? 4'd5 : volts;
    // Out-of-range tenths (10..15) fall into the upper sub-band.
    if (tenths <= 4'd3) begin
      sub = 2'd0;
    end else if (tenths <= 4'd6) begin
      sub = 2'd1;
    end else begin
      sub = 2'd2;
    end
    band     = ({1'b0, v_sat} * 5'd3) + {3'b000, sub};
    offset   = 16'(BAND_H) * {11'd0, band};
    row_full = 16'(BASE_ROW) - offset;
    top_row  = row_full[Y_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/scope_column_writer.sv
`default_nettype none
// scope_column_writer: redraws one frame-buffer column per vertical blank from a queued sample.
// Revision: 1.0
module scope_column_writer
  import scope_pkg::*;
#(
  parameter int H_PIX    = 640,
  parameter int V_PIX    = 480,
  parameter int BAND_H   = 13,
  parameter int BASE_ROW = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [1:0]          mode,
  input  logic                vblank_start,
  output logic                busy,
  output logic                fb_we,
  output logic [X_W-1:0]      fb_x,
  output logic [Y_W-1:0]      fb_y,
  output logic [COL_W-1:0]    fb_wdata
);

  localparam logic [X_W-1:0] X_LAST    = X_W'(H_PIX - 1);
  localparam logic [Y_W-1:0] Y_LAST    = Y_W'(V_PIX - 1);
  localparam logic [Y_W-1:0] BAND_LAST = Y_W'(BAND_H - 1);

  state_t              state, state_n;
  logic [X_W-1:0]      col_ptr, col_ptr_n;
  logic [X_W-1:0]      init_x, init_x_n;
  logic [Y_W-1:0]      row, row_n;
  logic                init_go, init_go_n;
  logic [SAMPLE_W-1:0] hold_data, hold_data_n;
  logic                hold_full, hold_full_n;
  logic                draw_en, draw_en_n;
  logic                done;
  logic                ready_n;
  logic                we_n;
  logic [X_W-1:0]      x_n;
  logic [Y_W-1:0]      y_n;
  logic [COL_W-1:0]    wdata_n;
  logic [Y_W-1:0]      top_row;

  scope_row_map #(
    .BAND_H   (BAND_H),
    .BASE_ROW (BASE_ROW)
  ) u_row_map (
    .sample_data (hold_data),
    .top_row     (top_row)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      col_ptr      <= '0;
      init_x       <= '0;
      row          <= '0;
      init_go      <= 1'b0;
      hold_data    <= '0;
      hold_full    <= 1'b0;
      draw_en      <= 1'b0;
      sample_ready <= 1'b0;
      fb_we        <= 1'b0;
      fb_x         <= '0;
      fb_y         <= '0;
      fb_wdata     <= '0;
    end else begin
      state        <= state_n;
      col_ptr      <= col_ptr_n;
      init_x       <= init_x_n;
      row          <= row_n;
      init_go      <= init_go_n;
      hold_data    <= hold_data_n;
      hold_full    <= hold_full_n;
      draw_en      <= draw_en_n;
      sample_ready <= ready_n;
      fb_we        <= we_n;
      fb_x         <= x_n;
      fb_y         <= y_n;
      fb_wdata     <= wdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    col_ptr_n   = col_ptr;
    init_x_n    = init_x;
    row_n       = row;
    init_go_n   = init_go;
    hold_data_n = hold_data;
    hold_full_n = hold_full;
    draw_en_n   = draw_en;
    done        = 1'b0;

    // Counters always name the pixel presented on fb_* while in that state.
    unique case (state)
      ST_INIT: begin
        if (!init_go) begin
          init_go_n = 1'b1;
        end else if (row == Y_LAST) begin
          row_n = '0;
          if (init_x == X_LAST) begin
            init_x_n = '0;
            state_n  = ST_IDLE;
          end else begin
            init_x_n = init_x + 1'b1;
          end
        end else begin
          row_n = row + 1'b1;
        end
      end
      ST_IDLE: begin
        if (vblank_start && hold_full) begin
          state_n   = ST_CLEAR;
          row_n     = '0;
          draw_en_n = (mode == 2'd0) || (mode == 2'd2);
        end
      end
      ST_CLEAR: begin
        if (row == Y_LAST) begin
          row_n = '0;
          if (draw_en) begin
            state_n = ST_DRAW;
          end else begin
            done = 1'b1;
          end
        end else begin
          row_n = row + 1'b1;
        end
      end
      ST_DRAW: begin
        if (row == BAND_LAST) begin
          done = 1'b1;
        end else begin
          row_n = row + 1'b1;
        end
      end
      default: state_n = ST_INIT;
    endcase

    if (done) begin
      state_n     = ST_IDLE;
      row_n       = '0;
      hold_full_n = 1'b0;
      col_ptr_n   = (col_ptr == X_LAST) ? '0 : col_ptr + 1'b1;
    end

    if (sample_valid && sample_ready) begin
      hold_full_n = 1'b1;
      hold_data_n = sample_data;
    end

    ready_n = (state_n != ST_INIT) && !hold_full_n;
  end

  always_comb begin
    we_n    = 1'b0;
    x_n     = '0;
    y_n     = '0;
    wdata_n = COL_BG;
    unique case (state_n)
      ST_INIT: begin
        if (init_go_n) begin
          we_n = 1'b1;
          x_n  = init_x_n;
          y_n  = row_n;
        end
      end
      ST_CLEAR: begin
        we_n    = 1'b1;
        x_n     = col_ptr_n;
        y_n     = row_n;
        wdata_n = ((row_n >= AXIS_TOP) && (row_n <= AXIS_BOT)) ? COL_AXIS : COL_BG;
      end
      ST_DRAW: begin
        we_n    = 1'b1;
        x_n     = col_ptr_n;
        y_n     = top_row + row_n;
        wdata_n = COL_TRACE;
      end
      default: begin
        we_n = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_scope_column_writer.sv
`default_nettype none
// tb_scope_column_writer: scoreboard bench for the scope column writer (4-column build).
// Revision: 1.0
module tb_scope_column_writer;
  import scope_pkg::*;

  localparam int H = 4;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [1:0]  mode = 2'd0;
  logic        vblank_start = 1'b0;
  logic        busy;
  logic        fb_we;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [11:0] fb_wdata;

  typedef logic [30:0] wr_t;
  wr_t exp_q[$];
  int  tests = 0;
  int  failures = 0;

  scope_column_writer #(.H_PIX(H), .V_PIX(V), .BAND_H(13), .BASE_ROW(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mode         (mode),
    .vblank_start (vblank_start),
    .busy         (busy),
    .fb_we        (fb_we),
    .fb_x         (fb_x),
    .fb_y         (fb_y),
    .fb_wdata     (fb_wdata)
  );

  always #20 clk = ~clk;

  // Every frame-buffer write is matched against the scoreboard.
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      wr_t e;
      tests++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL fb_write unexpected: got x=%0d y=%0d d=%h, required no write", fb_x, fb_y, fb_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({fb_x, fb_y, fb_wdata} !== e) begin
          failures++;
          $display("FAIL fb_write: got x=%0d y=%0d d=%h, required x=%0d y=%0d d=%h",
                   fb_x, fb_y, fb_wdata, e[30:21], e[20:12], e[11:0]);
        end
      end
    end
  end

  task automatic push_init();
    for (int x = 0; x < H; x++)
      for (int y = 0; y < V; y++)
        exp_q.push_back({10'(x), 9'(y), 12'h000});
  endtask

  task automatic push_column(input int x, input bit draw, input int top);
    for (int y = 0; y < V; y++)
      exp_q.push_back({10'(x), 9'(y), ((y >= 234 && y <= 246) ? 12'h0F0 : 12'h000)});
    if (draw)
      for (int i = 0; i < 13; i++)
        exp_q.push_back({10'(x), 9'(top + i), 12'h010});
  endtask

  task automatic send_sample(input logic [7:0] d, output bit ok);
    int n = 0;
    sample_data  = d;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    ok = (sample_ready === 1'b1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic run_column(input logic [1:0] mode_after, output bit first_we, output int n);
    vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
    mode = mode_after;
    first_we = (fb_we === 1'b1) && (fb_y === 9'd0);
    n = 0;
    repeat (2000) begin
      if (busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int rdy_hi = 0;
    int n = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (fb_we !== 1'b0 || fb_x !== 10'd0 || fb_y !== 9'd0 || fb_wdata !== 12'h000) begin
      failures++;
      $display("FAIL reset_fb: got we=%b x=%0d y=%0d d=%h, required 0/0/0/000", fb_we, fb_x, fb_y, fb_wdata);
    end
    tests++;
    if (busy !== 1'b1 || sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got busy=%b ready=%b, required busy=1 ready=0", busy, sample_ready);
    end
    tests++;
    if (dut.state !== ST_INIT || dut.col_ptr !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d col=%0d, required INIT col=0", dut.state, dut.col_ptr);
    end
    push_init();
    rst = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      if (sample_ready !== 1'b0) rdy_hi++;
    end
    tests++;
    if (rdy_hi != 0) begin
      failures++;
      $display("FAIL init_ready: got %0d cycles ready high, required 0", rdy_hi);
    end
    tests++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL init_done: got busy=%b pending=%0d after %0d cycles, required busy=0 pending=0", busy, exp_q.size(), n);
    end
    tests++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_ready_end: got %b, required 1", sample_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    bit fw;
    int n;
    mode = 2'd0;
    send_sample(8'h02, ok);
    tests++;
    if (!ok || sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_accept: got ok=%b ready=%b, required ok=1 ready=0", ok, sample_ready);
    end
    push_column(0, 1'b1, 256);
    run_column(2'd0, fw, n);
    tests++;
    if (!fw) begin
      failures++;
      $display("FAIL single_latency: got no row-0 write the cycle after vblank, required write");
    end
    tests++;
    if (n != 493) begin
      failures++;
      $display("FAIL single_busy_len: got %0d, required 493", n);
    end
    tests++;
    if (exp_q.size() != 0 || dut.col_ptr !== 10'd1 || sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_done: got pending=%0d col=%0d ready=%b, required 0/1/1", exp_q.size(), dut.col_ptr, sample_ready);
    end
  endtask

  task automatic test_row_map();
    logic [7:0] smp [3] = '{8'h59, 8'h14, 8'h7F};
    int         top [3] = '{35, 204, 35};
    int         col [3] = '{2, 3, 0};
    bit ok;
    bit fw;
    int n;
    for (int k = 0; k < 3; k++) begin
      send_sample(smp[k], ok);
      push_column(k + 1, 1'b1, top[k]);
      run_column(2'd2, fw, n);
      tests++;
      if (!ok || n != 493 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL row_map_%0d: got ok=%b len=%0d pending=%0d, required 1/493/0", k, ok, n, exp_q.size());
      end
      tests++;
      if (dut.col_ptr !== 10'(col[k])) begin
        failures++;
        $display("FAIL col_ptr_%0d: got %0d, required %0d", k, dut.col_ptr, col[k]);
      end
    end
  endtask

  task automatic test_no_sample();
    int we_cnt = 0;
    bit ok;
    bit fw;
    int n;
    vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
    repeat (20) begin
      if (fb_we !== 1'b0 || busy !== 1'b0) we_cnt++;
      @(negedge clk);
    end
    tests++;
    if (we_cnt != 0 || dut.col_ptr !== 10'd0) begin
      failures++;
      $display("FAIL empty_vblank: got %0d active cycles col=%0d, required 0 col=0", we_cnt, dut.col_ptr);
    end
    mode = 2'd1;
    send_sample(8'h30, ok);
    push_column(0, 1'b0, 0);
    run_column(2'd0, fw, n);
    tests++;
    if (!ok || !fw || n != 480) begin
      failures++;
      $display("FAIL clear_only: got ok=%b first=%b len=%0d, required 1/1/480", ok, fw, n);
    end
    tests++;
    if (exp_q.size() != 0 || dut.col_ptr !== 10'd1) begin
      failures++;
      $display("FAIL clear_only_done: got pending=%0d col=%0d, required 0/1", exp_q.size(), dut.col_ptr);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit fw;
    int n = 0;
    int rdy_hi = 0;
    mode = 2'd0;
    send_sample(8'h25, ok);
    sample_data  = 8'h48;
    sample_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (!ok || sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_hold_full: got ok=%b ready=%b, required 1/0", ok, sample_ready);
    end
    push_column(1, 1'b1, 165);
    push_column(2, 1'b1, 74);
    vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
    repeat (2000) begin
      if (busy !== 1'b1) break;
      n++;
      if (sample_ready !== 1'b0) rdy_hi++;
      vblank_start = (n == 50);
      @(negedge clk);
    end
    vblank_start = 1'b0;
    tests++;
    if (n != 493 || rdy_hi != 0) begin
      failures++;
      $display("FAIL b2b_first: got len=%0d ready_high=%0d, required 493/0", n, rdy_hi);
    end
    tests++;
    if (sample_ready !== 1'b1 || dut.col_ptr !== 10'd2) begin
      failures++;
      $display("FAIL b2b_ready_return: got ready=%b col=%0d, required 1/2", sample_ready, dut.col_ptr);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    tests++;
    if (sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: got ready=%b, required 0", sample_ready);
    end
    run_column(2'd0, fw, n);
    tests++;
    if (n != 493 || exp_q.size() != 0 || dut.col_ptr !== 10'd3) begin
      failures++;
      $display("FAIL b2b_second: got len=%0d pending=%0d col=%0d, required 493/0/3", n, exp_q.size(), dut.col_ptr);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit found = 1'b0;
    int n = 0;
    int we_cnt = 0;
    mode = 2'd0;
    send_sample(8'h33, ok);
    for (int y = 0; y <= 100; y++)
      exp_q.push_back({10'd3, 9'(y), ((y >= 234 && y <= 246) ? 12'h0F0 : 12'h000)});
    vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
    repeat (600) begin
      if (fb_we === 1'b1 && fb_y === 9'd100) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (!found || fb_we !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_we: got found=%b we=%b pending=%0d, required 1/0/0", found, fb_we, exp_q.size());
    end
    tests++;
    if (dut.state !== ST_INIT || dut.col_ptr !== 10'd0 || dut.hold_full !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_state: got state=%0d col=%0d full=%b busy=%b, required INIT/0/0/1",
               dut.state, dut.col_ptr, dut.hold_full, busy);
    end
    push_init();
    @(negedge clk);
    rst = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    tests++;
    if (busy !== 1'b0 || exp_q.size() != 0 || sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_reinit: got busy=%b pending=%0d ready=%b, required 0/0/1", busy, exp_q.size(), sample_ready);
    end
    vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
    repeat (20) begin
      if (fb_we !== 1'b0 || busy !== 1'b0) we_cnt++;
      @(negedge clk);
    end
    tests++;
    if (we_cnt != 0) begin
      failures++;
      $display("FAIL abort_discard: got %0d active cycles, required 0", we_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_row_map();
    test_no_sample();
    test_back_to_back();
    test_reset_abort();
    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #100000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
